rd_capture_sdr_16: RTL and testbench

//  Read-data return path directly downstream of the 16-bit SDRAM command FSM.
//  - Uses the FSM's cmd_read strobe (one pulse per READ, burst length 2) to time capture of dq_i after CAS latency.
//  - Packs each 2-beat burst into one 32-bit word.
//  - Buffers words in a small FIFO toward the egress/Wishbone side with a valid/ready handshake.

---
 rtl/rd_capture_sdr_16_pkg.sv | 35 +++
 rtl/rd_capture_sdr_16_fifo.sv | 50 +++++
 rtl/rd_capture_sdr_16.sv | 100 ++++++++++
 tb/tb_rd_capture_sdr_16.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rd_capture_sdr_16_pkg.sv
// Shared SDR-16 definitions: command encodings, CAS-latency codes, burst/beat
// geometry and the read-capture beat FSM state type.
package sdr_16_defs;

  localparam int BEAT_W    = 16;
  localparam int BURST_LEN = 2;
  localparam int WORD_W    = BEAT_W * BURST_LEN;

  // {cs_n, ras_n, cas_n, we_n}
  typedef enum logic [3:0] {
    CMD_LMR = 4'b0000,
    CMD_REF = 4'b0001,
    CMD_PRE = 4'b0010,
    CMD_ACT = 4'b0011,
    CMD_WR  = 4'b0100,
    CMD_RD  = 4'b0101,
    CMD_BST = 4'b0110,
    CMD_NOP = 4'b0111
  } sdr_cmd_t;

  typedef enum logic [2:0] {
    CL_2 = 3'd2,
    CL_3 = 3'd3
  } cas_lat_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BEAT1 = 1'b1
  } beat_state_t;

  function automatic bit rd_cfg_ok(int cl, int io_dly);
    return (cl >= 2) && (cl <= 3) && (io_dly >= 0) && (io_dly <= 2) && (cl + io_dly >= 1);
  endfunction

endpackage

// File: rtl/rd_capture_sdr_16_fifo.sv
// Small synchronous first-word-fall-through FIFO; also used on the egress side.
module rd_fifo_sync #(
  parameter int dw = 32,
  parameter int aw = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [dw-1:0] din,
  input  logic          pop,
  output logic [dw-1:0] dout,
  output logic          full,
  output logic          empty
);

  logic [dw-1:0] mem [2**aw];
  logic [aw:0]   wptr;
  logic [aw:0]   rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (wptr[aw] != rptr[aw]) && (wptr[aw-1:0] == rptr[aw-1:0]);
  assign empty   = (wptr == rptr);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  assign dout = empty ? '0 : mem[rptr[aw-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr[aw-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rd_capture_sdr_16.sv
// SDRAM read-data return path: times beat capture from cmd_read, packs 2-beat
// bursts into 32-bit words and queues them toward the consumer.
module rd_capture_sdr_16
  import sdr_16_defs::*;
#(
  parameter int cl      = 2,
  parameter int io_dly  = 1,
  parameter int fifo_aw = 2
) (
  input  logic                sdram_clk,
  input  logic                sdram_rst,
  input  logic                cmd_read,
  input  logic [BEAT_W-1:0]   dq_i,
  output logic [WORD_W-1:0]   dat_o,
  output logic                dat_vld_o,
  input  logic                dat_rdy_i,
  output logic                busy_o,
  output logic                overflow_o,
  output logic                proto_err_o
);

  localparam int L = cl + io_dly;

  if (!rd_cfg_ok(cl, io_dly)) begin : g_cfg_check
    $error("rd_capture_sdr_16: unsupported cl=%0d / io_dly=%0d", cl, io_dly);
  end

  logic [L-1:0]      dly;
  beat_state_t       state;
  logic [BEAT_W-1:0] hi_reg;
  logic              tap;
  logic              push;
  logic [WORD_W-1:0] push_word;
  logic              fifo_full;
  logic              fifo_empty;

  assign tap       = dly[L-1];
  assign push      = (state == ST_BEAT1);
  assign push_word = {hi_reg, dq_i};

  // Beat FSM: first beat parks in hi_reg, second beat completes the word.
  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      dly         <= '0;
      state       <= ST_IDLE;
      hi_reg      <= '0;
      overflow_o  <= 1'b0;
      proto_err_o <= 1'b0;
    end else begin
      dly[0] <= cmd_read;
      for (int i = 1; i < L; i++) begin
        dly[i] <= dly[i-1];
      end

      case (state)
        ST_IDLE: begin
          if (tap) begin
            hi_reg <= dq_i;
            state  <= ST_BEAT1;
          end
        end
        ST_BEAT1: begin
          if (tap) begin
            hi_reg      <= dq_i;
            proto_err_o <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (cmd_read && dly[0]) begin
        proto_err_o <= 1'b1;
      end
      // A pop in the same cycle frees a slot, so only an unserved full drops.
      if (push && fifo_full && !dat_rdy_i) begin
        overflow_o <= 1'b1;
      end
    end
  end

  rd_fifo_sync #(
    .dw(WORD_W),
    .aw(fifo_aw)
  ) u_fifo (
    .clk   (sdram_clk),
    .rst   (sdram_rst),
    .push  (push),
    .din   (push_word),
    .pop   (dat_rdy_i),
    .dout  (dat_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign dat_vld_o = !fifo_empty;
  assign busy_o    = (|dly) || (state == ST_BEAT1);

endmodule

// File: tb/tb_rd_capture_sdr_16.sv
// Directed scoreboard bench for rd_capture_sdr_16 (cl=2, io_dly=1, fifo_aw=2, L=3).
module tb_rd_capture_sdr_16;

  logic        sdram_clk = 1'b0;
  logic        sdram_rst;
  logic        cmd_read;
  logic [15:0] dq_i;
  logic [31:0] dat_o;
  logic        dat_vld_o;
  logic        dat_rdy_i;
  logic        busy_o;
  logic        overflow_o;
  logic        proto_err_o;

  typedef struct {
    logic [31:0] word;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          cyc        = 0;
  logic        cmdTbl [64];
  logic [15:0] dqTbl  [64];
  logic        rdyTbl [64];
  logic        rstTbl [64];

  rd_capture_sdr_16 #(.cl(2), .io_dly(1), .fifo_aw(2)) dut (
    .sdram_clk   (sdram_clk),
    .sdram_rst   (sdram_rst),
    .cmd_read    (cmd_read),
    .dq_i        (dq_i),
    .dat_o       (dat_o),
    .dat_vld_o   (dat_vld_o),
    .dat_rdy_i   (dat_rdy_i),
    .busy_o      (busy_o),
    .overflow_o  (overflow_o),
    .proto_err_o (proto_err_o)
  );

  always #5 sdram_clk = ~sdram_clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Monitor: every accepted word must match the head of the scoreboard, including its cycle.
  always @(negedge sdram_clk) begin
    if (dat_vld_o === 1'b1 && dat_rdy_i === 1'b1) begin
      exp_t e;
      compared++;
      if (sbq.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_word: got %h at cycle %0d, expected none", dat_o, cyc);
      end else begin
        e = sbq.pop_front();
        if (dat_o !== e.word || cyc != e.cyc) begin
          mismatched++;
          $display("[TB] FAIL word: got %h at cycle %0d, expected %h at cycle %0d",
                   dat_o, cyc, e.word, e.cyc);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, required);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_vld"},   32'(dat_vld_o),   32'd0);
    checkOutput({tag, "_busy"},  32'(busy_o),      32'd0);
    checkOutput({tag, "_dat"},   dat_o,            32'd0);
    checkOutput({tag, "_ovf"},   32'(overflow_o),  32'd0);
    checkOutput({tag, "_proto"}, 32'(proto_err_o), 32'd0);
  endtask

  task automatic driveCycle();
    sdram_rst = rstTbl[cyc];
    cmd_read  = cmdTbl[cyc];
    dq_i      = dqTbl[cyc];
    dat_rdy_i = rdyTbl[cyc];
  endtask

  task automatic applyStimulus(input int untilCyc);
    while (cyc < untilCyc) begin
      @(posedge sdram_clk);
      #1;
      cyc++;
      driveCycle();
    end
  endtask

  task automatic sampleAt(input int c);
    applyStimulus(c);
    @(negedge sdram_clk);
  endtask

  task automatic startTest(input string name);
    $display("[TB] starting %s", name);
    for (int i = 0; i < 64; i++) begin
      cmdTbl[i] = 1'b0;
      dqTbl[i]  = 16'h0000;
      rdyTbl[i] = 1'b0;
      rstTbl[i] = 1'b0;
    end
    sbq.delete();
    sdram_rst = 1'b1;
    cmd_read  = 1'b0;
    dq_i      = 16'h0000;
    dat_rdy_i = 1'b0;
    repeat (2) @(posedge sdram_clk);
    #1;
    cyc = 0;
  endtask

  task automatic endTest(input string name);
    checkOutput({name, "_sb_drained"}, 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    // T1: single read, word at cycle 15, busy 11..14
    startTest("T1");
    cmdTbl[10] = 1'b1;
    dqTbl[13]  = 16'hA5A5;
    dqTbl[14]  = 16'h5A5A;
    for (int i = 0; i < 64; i++) rdyTbl[i] = 1'b1;
    sbq.push_back('{32'hA5A55A5A, 15});
    driveCycle();
    sampleAt(0);
    checkIdle("reset");
    for (int c = 9; c <= 16; c++) begin
      sampleAt(c);
      checkOutput("T1_busy", 32'(busy_o), 32'((c >= 11 && c <= 14) ? 1 : 0));
    end
    applyStimulus(22);
    endTest("T1");

    // T2: streaming reads every two cycles
    startTest("T2");
    for (int k = 0; k < 4; k++) cmdTbl[10 + 2*k] = 1'b1;
    for (int k = 0; k < 8; k++) dqTbl[13 + k] = 16'(k + 1);
    for (int i = 0; i < 64; i++) rdyTbl[i] = 1'b1;
    sbq.push_back('{32'h00010002, 15});
    sbq.push_back('{32'h00030004, 17});
    sbq.push_back('{32'h00050006, 19});
    sbq.push_back('{32'h00070008, 21});
    driveCycle();
    sampleAt(25);
    checkOutput("T2_ovf",   32'(overflow_o),  32'd0);
    checkOutput("T2_proto", 32'(proto_err_o), 32'd0);
    endTest("T2");

    // T3: five reads into a 4-deep FIFO with no consumer, then drain
    startTest("T3");
    for (int k = 0; k < 5; k++) begin
      cmdTbl[10 + 2*k]    = 1'b1;
      dqTbl[13 + 2*k]     = 16'(((k + 1) << 8) | 1);
      dqTbl[13 + 2*k + 1] = 16'(((k + 1) << 8) | 2);
    end
    for (int i = 25; i < 64; i++) rdyTbl[i] = 1'b1;
    sbq.push_back('{32'h01010102, 25});
    sbq.push_back('{32'h02010202, 26});
    sbq.push_back('{32'h03010302, 27});
    sbq.push_back('{32'h04010402, 28});
    driveCycle();
    sampleAt(22);
    checkOutput("T3_ovf_before", 32'(overflow_o), 32'd0);
    sampleAt(23);
    checkOutput("T3_ovf_after", 32'(overflow_o), 32'd1);
    checkOutput("T3_vld_held",  32'(dat_vld_o),  32'd1);
    checkOutput("T3_head",      dat_o,           32'h01010102);
    sampleAt(32);
    checkOutput("T3_vld_drained", 32'(dat_vld_o),  32'd0);
    checkOutput("T3_ovf_sticky",  32'(overflow_o), 32'd1);
    endTest("T3");

    // T4: full FIFO, consumer pops in the same cycle as the fifth push
    startTest("T4");
    for (int k = 0; k < 5; k++) begin
      cmdTbl[10 + 2*k]    = 1'b1;
      dqTbl[13 + 2*k]     = 16'(((k + 1) << 8) | 1);
      dqTbl[13 + 2*k + 1] = 16'(((k + 1) << 8) | 2);
    end
    for (int i = 22; i < 64; i++) rdyTbl[i] = 1'b1;
    sbq.push_back('{32'h01010102, 22});
    sbq.push_back('{32'h02010202, 23});
    sbq.push_back('{32'h03010302, 24});
    sbq.push_back('{32'h04010402, 25});
    sbq.push_back('{32'h05010502, 26});
    driveCycle();
    sampleAt(30);
    checkOutput("T4_ovf", 32'(overflow_o), 32'd0);
    endTest("T4");

    // T5: back-to-back cmd_read is a protocol error; both overlapping words are pushed
    startTest("T5");
    cmdTbl[10] = 1'b1;
    cmdTbl[11] = 1'b1;
    dqTbl[13]  = 16'h1111;
    dqTbl[14]  = 16'h2222;
    dqTbl[15]  = 16'h3333;
    for (int i = 0; i < 64; i++) rdyTbl[i] = 1'b1;
    sbq.push_back('{32'h11112222, 15});
    sbq.push_back('{32'h22223333, 16});
    driveCycle();
    sampleAt(9);
    checkOutput("T5_proto_before", 32'(proto_err_o), 32'd0);
    sampleAt(15);
    checkOutput("T5_proto", 32'(proto_err_o), 32'd1);
    sampleAt(30);
    checkOutput("T5_proto_sticky", 32'(proto_err_o), 32'd1);
    endTest("T5");

    // T6: reset between the two beats discards the read
    startTest("T6");
    cmdTbl[10] = 1'b1;
    dqTbl[13]  = 16'hDEAD;
    dqTbl[14]  = 16'hBEEF;
    rstTbl[13] = 1'b1;
    for (int i = 0; i < 64; i++) rdyTbl[i] = 1'b1;
    driveCycle();
    sampleAt(0);
    checkIdle("T6_start");
    sampleAt(12);
    checkOutput("T6_busy", 32'(busy_o), 32'd1);
    sampleAt(14);
    checkIdle("T6_after_rst");
    applyStimulus(25);
    endTest("T6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
